// File: rtl/tick_scheduler.sv
// Shared base prescaler driving NCH runtime-programmable one-cycle tick channels.
// Define TICK_SCHEDULER_SQUARE_EN to add the per-channel o_sq square-wave outputs.
module tick_scheduler #(
   parameter int NCH      = 4,
   parameter int CH_W     = 2,
   parameter int DIV_W    = 16,
   parameter int BASE_DIV = 12000
) (
   input  logic             sysclk,
   input  logic             i_rst_n,
   input  logic             i_cfg_valid,
   output logic             o_cfg_ready,
   input  logic [CH_W-1:0]  i_cfg_ch,
   input  logic             i_cfg_en,
   input  logic [DIV_W-1:0] i_cfg_div,
   output logic             o_cfg_err,
   output logic             o_base_stb,
   output logic [NCH-1:0]   o_tick
`ifdef TICK_SCHEDULER_SQUARE_EN
   ,
   output logic [NCH-1:0]   o_sq
`endif
);

   localparam int              BW        = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
   localparam logic [BW-1:0]   BASE_LAST = BW'(BASE_DIV - 1);

   typedef enum logic {IDLE, APPLY} state_t;

   state_t           state;
   logic [BW-1:0]    base_cnt;
   logic             base_hit;
   logic [CH_W-1:0]  lat_ch;
   logic             lat_en;
   logic [DIV_W-1:0] lat_div;
   logic [NCH-1:0]   en;
   logic [DIV_W-1:0] div [NCH];
   logic [DIV_W-1:0] cnt [NCH];
   logic [NCH-1:0]   apply_hit;
   logic [NCH-1:0]   active;
   logic [NCH-1:0]   wrap;

   assign base_hit = (base_cnt == BASE_LAST);

   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge sysclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         base_cnt   <= '0;
         o_base_stb <= 1'b0;
      end else begin
         base_cnt   <= base_hit ? '0 : base_cnt + BW'(1);
         o_base_stb <= base_hit;
      end
   end

   // Ready is high exactly while IDLE, so it doubles as the accept qualifier.
   always_ff @(posedge sysclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= IDLE;
         o_cfg_ready <= 1'b1;
         o_cfg_err   <= 1'b0;
         lat_ch      <= '0;
         lat_en      <= 1'b0;
         lat_div     <= '0;
      end else begin
         o_cfg_err <= 1'b0;
         case (state)
            IDLE: begin
               if (i_cfg_valid && o_cfg_ready) begin
                  lat_ch      <= i_cfg_ch;
                  lat_en      <= i_cfg_en;
                  lat_div     <= i_cfg_div;
                  state       <= APPLY;
                  o_cfg_ready <= 1'b0;
                  o_cfg_err   <= (int'(i_cfg_ch) >= NCH);
               end
            end
            APPLY: begin
               state       <= IDLE;
               o_cfg_ready <= 1'b1;
            end
         endcase
      end
   end

   // An out-of-range latched channel matches no index, so the write is simply dropped.
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         apply_hit[i] = (state == APPLY) && (int'(lat_ch) == i);
         active[i]    = en[i] && (div[i] != '0);
         wrap[i]      = (cnt[i] == div[i] - DIV_W'(1));
      end
   end

   // NOTE: the divisor and counter arrays are explicit flops with a reset, not a RAM.
   always_ff @(posedge sysclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         en     <= '0;
         o_tick <= '0;
         for (int i = 0; i < NCH; i++) begin
            div[i] <= '0;
            cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NCH; i++) begin
            o_tick[i] <= 1'b0;
            if (apply_hit[i]) begin
               en[i]  <= lat_en;
               div[i] <= lat_div;
               cnt[i] <= '0;
            end else if (base_hit && active[i]) begin
               if (wrap[i]) begin
                  cnt[i]    <= '0;
                  o_tick[i] <= 1'b1;
               end else begin
                  cnt[i] <= cnt[i] + DIV_W'(1);
               end
            end
         end
      end
   end

`ifdef TICK_SCHEDULER_SQUARE_EN
   // Toggles on the same edge that registers the tick, so o_sq flips with o_tick.
   always_ff @(posedge sysclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_sq <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (apply_hit[i] && !lat_en) begin
               o_sq[i] <= 1'b0;
            end else if (!apply_hit[i] && base_hit && active[i] && wrap[i]) begin
               o_sq[i] <= ~o_sq[i];
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_tick_scheduler.sv
// Scoreboard bench for tick_scheduler with BASE_DIV=4, NCH=4, CH_W=3.
module tb_tick_scheduler;

   localparam int NCH      = 4;
   localparam int CH_W     = 3;
   localparam int DIV_W    = 16;
   localparam int BASE_DIV = 4;

   // Expected o_tick per base strobe k=1..20 of the first run ({ch3,ch2,ch1,ch0}).
   localparam logic [NCH-1:0] EXP_TICK [20] = '{
      4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
      4'h2, 4'h0, 4'h0, 4'h2, 4'h1,
      4'h1, 4'h7, 4'h1, 4'h5, 4'h1,
      4'h5, 4'h1, 4'h7, 4'h1, 4'h5
   };

   logic             sysclk    = 1'b0;
   logic             rst_n     = 1'b0;
   logic             cfg_valid = 1'b0;
   logic [CH_W-1:0]  cfg_ch    = '0;
   logic             cfg_en    = 1'b0;
   logic [DIV_W-1:0] cfg_div   = '0;
   logic             cfg_ready;
   logic             cfg_err;
   logic             base_stb;
   logic [NCH-1:0]   tick;
`ifdef TICK_SCHEDULER_SQUARE_EN
   logic [NCH-1:0]   sq;
`endif

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   logic [NCH-1:0] tick_q [$];
   logic           err_q  [$];

   tick_scheduler #(
      .NCH      (NCH),
      .CH_W     (CH_W),
      .DIV_W    (DIV_W),
      .BASE_DIV (BASE_DIV)
   ) dut (
      .sysclk      (sysclk),
      .i_rst_n     (rst_n),
      .i_cfg_valid (cfg_valid),
      .o_cfg_ready (cfg_ready),
      .i_cfg_ch    (cfg_ch),
      .i_cfg_en    (cfg_en),
      .i_cfg_div   (cfg_div),
      .o_cfg_err   (cfg_err),
      .o_base_stb  (base_stb),
      .o_tick      (tick)
`ifdef TICK_SCHEDULER_SQUARE_EN
      ,
      .o_sq        (sq)
`endif
   );

   always #5 sysclk = ~sysclk;

   always @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Monitor: pops expectations whenever the DUT presents a strobe or an APPLY cycle.
   always @(negedge sysclk) begin
      if (rst_n) begin
         check("tick_only_on_stb", 32'(tick & ~{NCH{base_stb}}), 32'd0);
         if (base_stb) begin
            check("base_phase", 32'(cyc % BASE_DIV), 32'd0);
            check("tick_q_nonempty", 32'(tick_q.size() > 0), 32'd1);
            if (tick_q.size() > 0) check("tick_vector", 32'(tick), 32'(tick_q.pop_front()));
         end
         if (!cfg_ready) begin
            check("err_q_nonempty", 32'(err_q.size() > 0), 32'd1);
            if (err_q.size() > 0) check("cfg_err", 32'(cfg_err), 32'(err_q.pop_front()));
         end else begin
            check("cfg_err_idle", 32'(cfg_err), 32'd0);
         end
      end
   end

   task automatic goto(input int n);
      int guard = 0;
      while (cyc < n && guard < 2000) begin
         @(posedge sysclk);
         #1;
         guard++;
      end
      check("goto_in_time", 32'(cyc >= n), 32'd1);
   endtask

   task automatic cfg_write(input logic [CH_W-1:0] ch, input logic en, input logic [DIV_W-1:0] dv,
                            input logic exp_err, input bit hold, output int apply_cyc);
      int waited = 0;
      cfg_ch    = ch;
      cfg_en    = en;
      cfg_div   = dv;
      cfg_valid = 1'b1;
      while (!cfg_ready && waited < 8) begin
         @(posedge sysclk);
         #1;
         waited++;
      end
      check("accept_in_time", 32'(waited < 8), 32'd1);
      err_q.push_back(exp_err);
      @(posedge sysclk);
      #1;
      if (!hold) cfg_valid = 1'b0;
      apply_cyc = cyc;
   endtask

   initial begin
      int a1;
      int a2;
      @(posedge sysclk);
      #1;
      check("rst_ready", 32'(cfg_ready), 32'd1);
      check("rst_err", 32'(cfg_err), 32'd0);
      check("rst_stb", 32'(base_stb), 32'd0);
      check("rst_tick", 32'(tick), 32'd0);
      repeat (2) @(posedge sysclk);
      #1;
      rst_n = 1'b1;
      for (int k = 0; k < 20; k++) tick_q.push_back(EXP_TICK[k]);

      goto(13);
      cfg_write(3'd1, 1'b1, 16'd3, 1'b0, 1'b0, a1);
      check("w1_apply_cyc", 32'(a1), 32'd14);
      check("w1_ready_low", 32'(cfg_ready), 32'd0);
      @(posedge sysclk);
      #1;
      check("w1_ready_back", 32'(cfg_ready), 32'd1);

      goto(37);
      cfg_write(3'd0, 1'b1, 16'd1, 1'b0, 1'b1, a1);
      cfg_write(3'd2, 1'b1, 16'd2, 1'b0, 1'b0, a2);
      check("b2b_first_apply", 32'(a1), 32'd38);
      check("b2b_spacing", 32'(a2 - a1), 32'd2);

      goto(58);
      cfg_write(3'd1, 1'b1, 16'd3, 1'b0, 1'b0, a1);
      check("strobe_apply_cyc", 32'(a1), 32'd59);

      goto(66);
      cfg_write(3'd3, 1'b1, 16'd0, 1'b0, 1'b0, a1);
      goto(70);
      cfg_write(3'd5, 1'b1, 16'd7, 1'b1, 1'b0, a1);
      check("oob_apply_cyc", 32'(a1), 32'd71);

      goto(82);
      cfg_write(3'd1, 1'b1, 16'd1, 1'b0, 1'b0, a1);
      check("rst_apply_cyc", 32'(a1), 32'd83);
      check("tick_q_drained", 32'(tick_q.size()), 32'd0);
      rst_n     = 1'b0;
      cfg_valid = 1'b0;
      #1;
      check("mid_rst_ready", 32'(cfg_ready), 32'd1);
      check("mid_rst_err", 32'(cfg_err), 32'd0);
      check("mid_rst_stb", 32'(base_stb), 32'd0);
      check("mid_rst_tick", 32'(tick), 32'd0);
      err_q.delete();
      repeat (2) @(posedge sysclk);
      #1;
      check("held_rst_stb", 32'(base_stb), 32'd0);
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) tick_q.push_back('0);

      goto(22);
      check("final_tick_q_empty", 32'(tick_q.size()), 32'd0);
      check("final_err_q_empty", 32'(err_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
